// File: rtl/rank_axi_burst_slave.sv
// rank_axi_burst_slave
//   AXI4 burst responder backed by a 2^(ADDR_WIDTH-2) word memory. One
//   transaction is in flight at a time; write and read address channels are
//   arbitrated round-robin, with write favoured out of reset.
//
// Ports
//   ACLK, ARESET                      clock, synchronous active-high reset
//   AWADDR/AWLEN/AWBURST/AWVALID/AWREADY   write address channel
//   WDATA/WSTRB/WLAST/WVALID/WREADY        write data channel
//   BRESP/BVALID/BREADY                    write response channel
//   ARADDR/ARLEN/ARBURST/ARVALID/ARREADY   read address channel
//   RDATA/RRESP/RLAST/RVALID/RREADY        read data channel
//
// Bursts: FIXED, INCR (wraps modulo the address space) and WRAP with
// LEN in {1,3,7,15}. Illegal WRAP lengths and the reserved burst type are
// carried out as INCR but answered with SLVERR. A WLAST that disagrees with
// the beat count does not end the burst early; it only flags SLVERR on B.
module rank_axi_burst_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]                      AWLEN,
  input  logic [1:0]                      AWBURST,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                            WLAST,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]                      ARLEN,
  input  logic [1:0]                      ARBURST,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RLAST,
  output logic                            RVALID,
  input  logic                            RREADY
);

  localparam int          AW    = C_S_AXI_ADDR_WIDTH;
  localparam int          DW    = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW    = DW / 8;
  localparam int          WORDS = 2 ** (AW - 2);

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;
  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WDATA,
    S_WRESP,
    S_RDATA
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [DW-1:0]   r_mem [WORDS];

  logic            r_awready;
  logic            r_arready;
  logic            r_prio_wr;
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_len;
  logic [1:0]      r_burst;
  logic [7:0]      r_beat;
  logic            r_werr;
  logic [1:0]      r_bresp;
  logic [1:0]      r_rresp;
  logic            r_rlast;
  logic [DW-1:0]   r_rdata;

  logic            w_aw_hs;
  logic            w_ar_hs;
  logic            w_w_hs;
  logic            w_r_hs;
  logic            w_last_beat;
  logic            w_wlast_bad;
  logic [AW-1:0]   w_next_addr;

  function automatic logic f_burst_err(input logic [1:0] b, input logic [7:0] l);
    return (b == BURST_RSVD) ||
           ((b == BURST_WRAP) && !((l == 8'd1) || (l == 8'd3) || (l == 8'd7) || (l == 8'd15)));
  endfunction

  function automatic logic [1:0] f_eff_burst(input logic [1:0] b, input logic [7:0] l);
    return f_burst_err(b, l) ? BURST_INCR : b;
  endfunction

  // WRAP keeps the bits above the (LEN+1)*4 window and increments inside it.
  function automatic logic [AW-1:0] f_next(input logic [AW-1:0] a, input logic [7:0] l,
                                           input logic [1:0] b);
    logic [AW-1:0] inc;
    logic [AW-1:0] mask;
    inc  = a + AW'(4);
    mask = AW'({l, 2'b11});
    case (b)
      BURST_FIXED: return a;
      BURST_WRAP:  return (a & ~mask) | (inc & mask);
      default:     return inc;
    endcase
  endfunction

  assign w_aw_hs     = (r_state == S_IDLE) && r_awready && AWVALID;
  assign w_ar_hs     = (r_state == S_IDLE) && r_arready && ARVALID;
  assign w_w_hs      = (r_state == S_WDATA) && WVALID;
  assign w_r_hs      = (r_state == S_RDATA) && RREADY;
  assign w_last_beat = (r_beat == r_len);
  assign w_wlast_bad = (WLAST != w_last_beat);
  assign w_next_addr = f_next(r_addr, r_len, r_burst);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    WREADY      = 1'b0;
    BVALID      = 1'b0;
    RVALID      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_aw_hs) begin
          w_state_nxt = S_WDATA;
        end else if (w_ar_hs) begin
          w_state_nxt = S_RDATA;
        end
      end
      S_WDATA: begin
        WREADY = 1'b1;
        if (w_w_hs && w_last_beat) begin
          w_state_nxt = S_WRESP;
        end
      end
      S_WRESP: begin
        BVALID = 1'b1;
        if (BREADY) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RDATA: begin
        RVALID = 1'b1;
        if (RREADY && r_rlast) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign AWREADY = r_awready;
  assign ARREADY = r_arready;
  assign BRESP   = r_bresp;
  assign RRESP   = r_rresp;
  assign RLAST   = r_rlast;
  assign RDATA   = r_rdata;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_awready <= 1'b0;
      r_arready <= 1'b0;
      r_prio_wr <= 1'b1;
      r_addr    <= '0;
      r_len     <= '0;
      r_burst   <= '0;
      r_beat    <= '0;
      r_werr    <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_rresp   <= RESP_OKAY;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_awready || r_arready) begin
            // Ready is a single-cycle pulse; capture only if valid is still up.
            r_awready <= 1'b0;
            r_arready <= 1'b0;
            if (w_aw_hs) begin
              r_addr  <= AWADDR;
              r_len   <= AWLEN;
              r_burst <= f_eff_burst(AWBURST, AWLEN);
              r_werr  <= f_burst_err(AWBURST, AWLEN);
              r_beat  <= '0;
            end
            if (w_ar_hs) begin
              r_addr  <= ARADDR;
              r_len   <= ARLEN;
              r_burst <= f_eff_burst(ARBURST, ARLEN);
              r_beat  <= '0;
              r_rdata <= r_mem[ARADDR[AW-1:2]];
              r_rlast <= (ARLEN == 8'd0);
              r_rresp <= f_burst_err(ARBURST, ARLEN) ? RESP_SLVERR : RESP_OKAY;
            end
          end else if (AWVALID && (!ARVALID || r_prio_wr)) begin
            // Priority only moves when both channels actually contend.
            r_awready <= 1'b1;
            if (ARVALID) begin
              r_prio_wr <= 1'b0;
            end
          end else if (ARVALID) begin
            r_arready <= 1'b1;
            if (AWVALID) begin
              r_prio_wr <= 1'b1;
            end
          end
        end
        S_WDATA: begin
          if (w_w_hs) begin
            r_addr <= w_next_addr;
            r_beat <= r_beat + 8'd1;
            if (w_wlast_bad) begin
              r_werr <= 1'b1;
            end
            if (w_last_beat) begin
              r_bresp <= (r_werr || w_wlast_bad) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        S_WRESP: begin
        end
        S_RDATA: begin
          if (w_r_hs) begin
            if (r_rlast) begin
              r_rlast <= 1'b0;
            end else begin
              r_addr  <= w_next_addr;
              r_beat  <= r_beat + 8'd1;
              r_rdata <= r_mem[w_next_addr[AW-1:2]];
              r_rlast <= ((r_beat + 8'd1) == r_len);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Memory has no reset so that data written before a reset survives it.
  always_ff @(posedge ACLK) begin
    if (!ARESET && w_w_hs) begin
      for (int unsigned i = 0; i < SW; i++) begin
        if (WSTRB[i]) begin
          r_mem[r_addr[AW-1:2]][8*i +: 8] <= WDATA[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: doc/rank_axi_burst_slave.md
RANK_AXI_BURST_SLAVE -- requirements
Module: rank_axi_burst_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 8, byte address width; memory holds 2^(ADDR_WIDTH-2) words.
REQ-003 SHALL provide ports, one per line, name direction width meaning:
- ACLK in 1: the single clock; all logic on the rising edge.
- ARESET in 1: reset, synchronous, active-high.
- AWADDR in 8: write burst start byte address.
- AWLEN in 8: write beats minus 1.
- AWBURST in 2: 0 FIXED, 1 INCR, 2 WRAP, 3 reserved.
- AWVALID in 1 / AWREADY out 1: write address handshake.
- WDATA in 32: write beat data.
- WSTRB in 4: byte enables.
- WLAST in 1: master's last-beat flag.
- WVALID in 1 / WREADY out 1: write data handshake.
- BRESP out 2: 0 OKAY, 2 SLVERR.
- BVALID out 1 / BREADY in 1: write response handshake.
- ARADDR in 8: read burst start byte address.
- ARLEN in 8: read beats minus 1.
- ARBURST in 2: same encoding as AWBURST.
- ARVALID in 1 / ARREADY out 1: read address handshake.
- RDATA out 32: read beat data.
- RRESP out 2: 0 OKAY, 2 SLVERR.
- RLAST out 1: final read beat.
- RVALID out 1 / RREADY in 1: read data handshake.

Function
REQ-004 SHALL implement an AXI4 burst responder; one transaction in flight at a time; states IDLE, WDATA, WRESP, RDATA.
REQ-005 IDLE: when AWVALID or ARVALID is sampled high, SHALL assert the chosen AWREADY or ARREADY for exactly one cycle, registered, one cycle after the valid is first seen.
REQ-006 SHALL capture address, length and burst type on the handshake.
REQ-007 When both are valid, SHALL arbitrate round-robin; write wins after reset.
REQ-008 WDATA: WREADY=1 from the cycle after the AW handshake.
REQ-009 Each accepted W beat SHALL write the bytes enabled by WSTRB to mem[addr[7:2]], then advance the address.
REQ-010 After AWLEN+1 accepted beats, SHALL enter WRESP; BVALID=1 on the next cycle.
REQ-011 Burst end SHALL be decided by the beat count only. A WLAST mismatch (early or missing) SHALL still write the data and SHALL set BRESP=SLVERR.
REQ-012 WRESP: BVALID and BRESP SHALL hold stable until BREADY; return to IDLE the cycle after the B handshake.
REQ-013 RDATA: RVALID=1 the cycle after the AR handshake, with RDATA=mem[addr].
REQ-014 Reads SHALL sustain one beat per cycle while RREADY=1; RDATA/RRESP/RLAST SHALL hold while RVALID=1 and RREADY=0.
REQ-015 RLAST=1 only on beat ARLEN+1; return to IDLE the cycle after the final handshake.
REQ-016 Address update per burst type:
- FIXED: address constant.
- INCR: +4, wrapping modulo 2^ADDR_WIDTH.
- WRAP: +4 within an aligned (LEN+1)*4 byte window.
REQ-017 WRAP with LEN not in {1,3,7,15}, or burst type 3, SHALL still perform the transfers as INCR and SHALL return SLVERR on every R beat or on B.
REQ-018 Low two address bits SHALL be ignored; accesses are always full-word.

Reset
REQ-019 While ARESET=1 at an edge: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BRESP and RRESP = 0; state=IDLE; arbiter favours write.
REQ-020 Reset mid-burst SHALL abandon the transaction with no response. Memory contents SHALL NOT be reset; beats written before reset SHALL persist.

Verification
REQ-021 INCR len 7 write of 1..8 at 0x00, then INCR len 7 read -> RDATA 1..8, RLAST on beat 8 only, BRESP=0, RRESP=0.
REQ-022 0x11223344 at 0x10, then single beat 0xAABBCCDD with WSTRB=0011 -> read 0x1122CCDD.
REQ-023 WRAP len 3 at 0x18 writing A,B,C,D -> word 0x18=A, 0x1C=B, 0x10=C, 0x14=D; OKAY.
REQ-024 AWVALID and ARVALID raised in the same cycle -> AWREADY first; ARREADY only after the B handshake; the following pair -> read first.
REQ-025 BREADY low for 10 cycles after the last W beat -> BVALID=1 and BRESP stable throughout, ARREADY=0 and AWREADY=0.
REQ-026 Other error and reset cases:
- WLAST high on beat 2 of len 3 -> 4 beats accepted, BRESP=2.
- ARESET high during beat 3 of 8 read -> RVALID=0 next cycle; a new read returns the pre-reset memory data.
